mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/includes.sv | 11 +
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/includes.sv
// includes: shared width macros and the arbiter state encoding.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_DATA
`define W_DATA 32
`endif

package includes;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction and data caches.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_DATA
`define W_DATA 32
`endif

module mem_arbiter
    import includes::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [1:0]           i_size,
    input  logic [`W_ADDR-1:0]   i_addr,
    input  logic [`W_DATA-1:0]   i_data_w,
    output logic [`W_DATA-1:0]   i_data_r,
    output logic                 i_addr_o,
    output logic                 i_data_o,
    input  logic                 d_en,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic [`W_ADDR-1:0]   d_addr,
    input  logic [`W_DATA-1:0]   d_data_w,
    output logic [`W_DATA-1:0]   d_data_r,
    output logic                 d_addr_o,
    output logic                 d_data_o,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic [`W_ADDR-1:0]   mem_addr,
    output logic [`W_DATA-1:0]   mem_data_w,
    input  logic [`W_DATA-1:0]   mem_data_r,
    input  logic                 mem_addr_o,
    input  logic                 mem_data_o
);
    state_t state, nxt;
    logic   addr_acc, last;
    logic   sel_i, sel_d, own_en, oth_en;

    assign sel_i  = state == GNT_I;
    assign sel_d  = state == GNT_D;
    assign own_en = sel_i ? i_en : d_en;
    assign oth_en = sel_i ? d_en : i_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_acc <= 1'b0;
            last     <= 1'b0;
        end else begin
            state    <= nxt;
            addr_acc <= (state != IDLE) && (nxt == state) && (addr_acc || mem_addr_o);
            if (state != IDLE && mem_data_o)
                last <= sel_d;
        end
    end

    // Completion hands over straight to a waiting requester; an unaccepted, withdrawn request aborts.
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = (i_en && d_en) ? ((RR && !last) ? GNT_D : (RR ? GNT_I : GNT_D)) :
                  d_en ? GNT_D : i_en ? GNT_I : IDLE;
        else if (mem_data_o)
            nxt = oth_en ? (sel_i ? GNT_D : GNT_I) : IDLE;
        else if (!addr_acc && !own_en)
            nxt = IDLE;
    end

    always_comb begin
        mem_en     = (sel_i || sel_d) && own_en && !addr_acc;
        mem_we     = sel_i ? i_we     : sel_d ? d_we     : 1'b0;
        mem_size   = sel_i ? i_size   : sel_d ? d_size   : 2'b00;
        mem_addr   = sel_i ? i_addr   : sel_d ? d_addr   : '0;
        mem_data_w = sel_i ? i_data_w : sel_d ? d_data_w : '0;
        i_addr_o   = sel_i && mem_addr_o;
        i_data_o   = sel_i && mem_data_o;
        d_addr_o   = sel_d && mem_addr_o;
        d_data_o   = sel_d && mem_data_o;
        i_data_r   = mem_data_r;
        d_data_r   = mem_data_r;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against an owner/queue style reference model.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_en, i_we, d_en, d_we, mem_addr_o, mem_data_o;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_data_w, d_addr, d_data_w, mem_data_r;
    logic [31:0] i_data_r, d_data_r, mem_addr, mem_data_w;
    logic        i_addr_o, i_data_o, d_addr_o, d_data_o, mem_en, mem_we;
    logic [1:0]  mem_size;
    int          checks = 0, fails = 0;
    int          owner = 0;
    bit          acc = 0, lst = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_en(i_en), .i_we(i_we), .i_size(i_size), .i_addr(i_addr), .i_data_w(i_data_w),
        .i_data_r(i_data_r), .i_addr_o(i_addr_o), .i_data_o(i_data_o),
        .d_en(d_en), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_data_w(d_data_w),
        .d_data_r(d_data_r), .d_addr_o(d_addr_o), .d_data_o(d_data_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic clr();
        {i_en, i_we, d_en, d_we, mem_addr_o, mem_data_o} = '0;
        {i_size, d_size} = '0;
        {i_addr, i_data_w, d_addr, d_data_w, mem_data_r} = '0;
    endtask

    // owner: 0 nobody, 1 instruction side, 2 data side
    task automatic model_step();
        bit xen, oen;
        if (owner == 0) begin
            if (i_en && d_en) owner = lst ? 1 : 2;
            else if (d_en) owner = 2;
            else if (i_en) owner = 1;
        end else begin
            xen = (owner == 1) ? i_en : d_en;
            oen = (owner == 1) ? d_en : i_en;
            if (mem_data_o) begin
                lst = (owner == 2);
                owner = oen ? 3 - owner : 0;
                acc = 0;
            end else if (!acc && !xen) owner = 0;
            else acc = acc | mem_addr_o;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check();
        logic [4:0]  ec;
        logic [66:0] eb;
        #3;
        ec = '0;
        eb = '0;
        if (owner == 1) begin
            ec = {i_en & ~acc, mem_addr_o, mem_data_o, 2'b00};
            eb = {i_we, i_size, i_addr, i_data_w};
        end
        if (owner == 2) begin
            ec = {d_en & ~acc, 2'b00, mem_addr_o, mem_data_o};
            eb = {d_we, d_size, d_addr, d_data_w};
        end
        cmp("ctrl", {mem_en, i_addr_o, i_data_o, d_addr_o, d_data_o}, ec);
        if (owner != 0) cmp("bus", {mem_we, mem_size, mem_addr, mem_data_w}, eb);
        cmp("rdata", {i_data_r, d_data_r}, {mem_data_r, mem_data_r});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        owner = 0; acc = 0; lst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check();
    endtask

    initial begin
        clr();
        do_reset();
        // single instruction read
        step(); i_en = 1; i_addr = 32'h0000_1000; i_size = 2; check();
        cmp("r029_idle_latency", mem_en, 0);
        step(); mem_addr_o = 1; check();
        cmp("r029_mem_en", mem_en, 1);
        cmp("r029_addr", mem_addr, 32'h0000_1000);
        cmp("r029_we", mem_we, 0);
        cmp("r029_addr_o", i_addr_o, 1);
        step(); mem_addr_o = 0; mem_data_o = 1; mem_data_r = 32'hDEAD_BEEF; i_en = 0; check();
        cmp("r029_data_o", i_data_o, 1);
        cmp("r029_rdata", i_data_r, 32'hDEAD_BEEF);
        step(); clr(); mem_data_o = 1; check();
        cmp("r029_idle_strobe", i_data_o, 0);
        step(); clr(); check();
        // simultaneous requests, round robin from reset
        do_reset();
        step(); i_en = 1; d_en = 1; i_addr = 32'hA0; d_addr = 32'hB0; check();
        step(); mem_addr_o = 1; mem_data_o = 1; check();
        cmp("r030_d_first", mem_addr, 32'hB0);
        cmp("r030_d_done", {d_data_o, i_data_o}, 2'b10);
        step(); mem_addr_o = 0; mem_data_o = 0; check();
        cmp("r030_i_direct", {mem_en, mem_addr}, {1'b1, 32'hA0});
        step(); i_en = 0; d_en = 0; check();
        step(); i_en = 1; d_en = 1; check();
        cmp("r030_abort_idle", mem_en, 0);
        step(); check();
        cmp("r030_last_kept", mem_addr, 32'hA0);
        // data write, accepted and completed together
        do_reset();
        step(); d_en = 1; d_we = 1; d_size = 2; d_addr = 32'h2000; d_data_w = 32'h1234_5678; check();
        step(); mem_addr_o = 1; mem_data_o = 1; check();
        cmp("r032_strobes", {d_addr_o, d_data_o}, 2'b11);
        cmp("r032_wdata", {mem_we, mem_data_w}, {1'b1, 32'h1234_5678});
        step(); clr(); check();
        cmp("r032_after", mem_en, 0);
        // asynchronous reset mid-transfer
        do_reset();
        step(); i_en = 1; check();
        step(); mem_addr_o = 1; check();
        step(); mem_addr_o = 0; check();
        cmp("r033_acc", mem_en, 0);
        mem_data_o = 1;
        #1 cmp("r033_pre", i_data_o, 1);
        rst = 1;
        #1 cmp("r033_async", {mem_en, i_addr_o, i_data_o}, 3'b000);
        do_reset();
        // abort before acceptance, pending instruction request
        step(); d_en = 1; check();
        step(); d_en = 0; i_en = 1; i_addr = 32'hA4; check();
        cmp("r034_dropped", mem_en, 0);
        step(); check();
        cmp("r034_idle", mem_en, 0);
        step(); check();
        cmp("r034_i_grant", {mem_en, mem_addr}, {1'b1, 32'hA4});
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            i_en = ($urandom_range(0, 9) < 6);
            d_en = ($urandom_range(0, 9) < 6);
            {i_we, d_we} = 2'($urandom);
            {i_size, d_size} = 4'($urandom);
            i_addr = $urandom; d_addr = $urandom;
            i_data_w = $urandom; d_data_w = $urandom; mem_data_r = $urandom;
            mem_addr_o = ($urandom_range(0, 9) < 3);
            mem_data_o = ($urandom_range(0, 9) < 3);
            check();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
